// File: rtl/mem_block_fetch_if.sv
// mem_block_fetch_if: cache refill request, main-memory read channel and assembled-line result
// master: cache/memory side (drives request and read data); slave: the fetch engine
interface mem_block_fetch_if #(
   parameter int WORD_SIZE  = 32,
   parameter int WORD_COUNT = 4
);
   localparam int IW = $clog2(WORD_COUNT);
   logic                            req_valid;
   logic                            req_ready;
   logic [12:0]                     req_block_addr;
   logic [IW-1:0]                   req_offset;
   logic                            mem_rd;
   logic [12+IW:0]                  mem_addr;
   logic [WORD_SIZE-1:0]            mem_rdata;
   logic                            mem_rvalid;
   logic [WORD_SIZE*WORD_COUNT-1:0] line_data;
   logic                            line_valid;
   logic                            err;
   logic [15:0]                     fetch_count;
   modport master (
      output req_valid, req_block_addr, req_offset, mem_rdata, mem_rvalid,
      input  req_ready, mem_rd, mem_addr, line_data, line_valid, err, fetch_count
   );
   modport slave (
      input  req_valid, req_block_addr, req_offset, mem_rdata, mem_rvalid,
      output req_ready, mem_rd, mem_addr, line_data, line_valid, err, fetch_count
   );
endinterface

// File: rtl/mem_block_fetch.sv
// mem_block_fetch: refills one cache block by issuing WORD_COUNT single-word memory reads
// Ports: clk (rising edge), rst (async, active-high), bus (slave modport of mem_block_fetch_if):
//   req_valid/req_ready/req_block_addr/req_offset request handshake, mem_rd/mem_addr/mem_rdata/
//   mem_rvalid memory channel, line_data/line_valid result, err timeout pulse, fetch_count refills.
// Macro CRITICAL_WORD_FIRST_EN: fetch starts at req_offset and wraps; default fetches from word 0.
module mem_block_fetch #(
   parameter int WORD_SIZE  = 32,
   parameter int WORD_COUNT = 4,
   parameter int TIMEOUT    = 64
) (
   input logic               clk,
   input logic               rst,
   mem_block_fetch_if.slave  bus
);
   localparam int IW = $clog2(WORD_COUNT);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t        state;
   logic [12:0]   blk;
   logic [IW-1:0] idx;
   logic [IW-1:0] cnt;
   logic [7:0]    tcnt;
   logic [IW-1:0] start;
`ifdef CRITICAL_WORD_FIRST_EN
   assign start = bus.req_offset;
`else
   assign start = '0;
`endif
   assign bus.req_ready = state == IDLE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         blk             <= '0;
         idx             <= '0;
         cnt             <= '0;
         tcnt            <= '0;
         bus.mem_rd      <= 1'b0;
         bus.mem_addr    <= '0;
         bus.line_data   <= '0;
         bus.line_valid  <= 1'b0;
         bus.err         <= 1'b0;
         bus.fetch_count <= '0;
      end else begin
         bus.mem_rd     <= 1'b0;
         bus.line_valid <= 1'b0;
         bus.err        <= 1'b0;
         case (state)
            IDLE: if (bus.req_valid) begin
               blk          <= bus.req_block_addr;
               idx          <= start;
               cnt          <= '0;
               tcnt         <= '0;
               bus.mem_rd   <= 1'b1;
               bus.mem_addr <= {bus.req_block_addr, start};
               state        <= ISSUE;
            end
            ISSUE: begin
               tcnt  <= '0;
               state <= WAIT;
            end
            WAIT: if (bus.mem_rvalid) begin
               bus.line_data[idx*WORD_SIZE +: WORD_SIZE] <= bus.mem_rdata;
               cnt <= cnt + 1'b1;
               if (cnt == IW'(WORD_COUNT - 1))
                  state <= DONE;
               else begin
                  // next word wraps modulo WORD_COUNT through the index width
                  idx          <= idx + 1'b1;
                  bus.mem_rd   <= 1'b1;
                  bus.mem_addr <= {blk, idx + 1'b1};
                  state        <= ISSUE;
               end
            end else if (tcnt == 8'(TIMEOUT - 1)) begin
               bus.err <= 1'b1;
               state   <= IDLE;
            end else
               tcnt <= tcnt + 1'b1;
            DONE: begin
               bus.line_valid <= 1'b1;
               if (bus.fetch_count != 16'hFFFF)
                  bus.fetch_count <= bus.fetch_count + 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_block_fetch.sv
// tb_mem_block_fetch: scoreboard bench for mem_block_fetch with a one-cycle-latency memory model
module tb_mem_block_fetch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_bad = 0;
   logic [14:0]  exp_addr[$];
   logic [127:0] exp_line[$];
   logic [15:0]  exp_fcq[$];
   logic [15:0]  exp_fc = '0;
   logic [31:0]  dbase = '0;
   int resp_cnt = 0;
   int resp_limit = 1000000;
   int inj_req = 0;
   int inj_ack = 0;
   int rd_seen = 0;
   int lv_seen = 0;
   int err_seen = 0;
   mem_block_fetch_if #(.WORD_SIZE(32), .WORD_COUNT(4)) u_if();
   mem_block_fetch #(.WORD_SIZE(32), .WORD_COUNT(4), .TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic expect_fetch(input logic [12:0] b, input logic [1:0] off, input int nw, input logic [31:0] base);
      int st;
      logic [127:0] line;
`ifdef CRITICAL_WORD_FIRST_EN
      st = int'(off);
`else
      st = 0;
`endif
      dbase = base;
      for (int k = 0; k < nw; k++) exp_addr.push_back({b, 2'(st + k)});
      if (nw == 4) begin
         for (int j = 0; j < 4; j++) line[32*j +: 32] = base + 32'(j);
         if (exp_fc != 16'hFFFF) exp_fc = exp_fc + 1'b1;
         exp_line.push_back(line);
         exp_fcq.push_back(exp_fc);
      end
   endtask
   task automatic request(input logic [12:0] b, input logic [1:0] off, input int nw, input logic [31:0] base);
      @(negedge clk);
      expect_fetch(b, off, nw, base);
      u_if.req_valid = 1'b1;
      u_if.req_block_addr = b;
      u_if.req_offset = off;
      @(posedge clk);
      #1 u_if.req_valid = 1'b0;
   endtask
   task automatic wait_lv(input int target);
      int c;
      for (c = 0; c < 80 && lv_seen < target; c++) begin
         @(negedge clk);
         #2;
      end
      check("wait_line_valid", 128'(lv_seen >= target), 128'd1);
   endtask
   // memory: answers each mem_rd in the following cycle with dbase + word index
   initial begin
      logic pend;
      logic [14:0] paddr;
      pend = 1'b0;
      paddr = '0;
      u_if.mem_rvalid = 1'b0;
      u_if.mem_rdata = '0;
      forever begin
         @(negedge clk);
         u_if.mem_rvalid = 1'b0;
         if (pend) begin
            u_if.mem_rvalid = 1'b1;
            u_if.mem_rdata = dbase + 32'(paddr[1:0]);
            pend = 1'b0;
         end else if (inj_ack != inj_req) begin
            u_if.mem_rvalid = 1'b1;
            u_if.mem_rdata = 32'hDEAD_BEEF;
            inj_ack++;
         end
         if (u_if.mem_rd && resp_cnt < resp_limit) begin
            pend = 1'b1;
            paddr = u_if.mem_addr;
            resp_cnt++;
         end
      end
   end
   initial begin
      forever begin
         @(negedge clk);
         if (u_if.mem_rd) begin
            rd_seen++;
            if (exp_addr.size() == 0) check("unexpected_mem_rd", 128'd1, 128'd0);
            else check("mem_addr", 128'(u_if.mem_addr), 128'(exp_addr.pop_front()));
         end
         if (u_if.line_valid) begin
            lv_seen++;
            if (exp_line.size() == 0) check("unexpected_line_valid", 128'd1, 128'd0);
            else begin
               check("line_data", u_if.line_data, exp_line.pop_front());
               check("fetch_count", 128'(u_if.fetch_count), 128'(exp_fcq.pop_front()));
            end
         end
         if (u_if.err) err_seen++;
      end
   end
   initial begin
      int n, lv0, rd0, acc, t1, t2, c;
      u_if.req_valid = 1'b0;
      u_if.req_block_addr = '0;
      u_if.req_offset = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_req_ready", 128'(u_if.req_ready), 128'd1);
      check("rst_mem_rd", 128'(u_if.mem_rd), 128'd0);
      check("rst_mem_addr", 128'(u_if.mem_addr), 128'd0);
      check("rst_line_data", u_if.line_data, 128'd0);
      check("rst_line_valid", 128'(u_if.line_valid), 128'd0);
      check("rst_err", 128'(u_if.err), 128'd0);
      check("rst_fetch_count", 128'(u_if.fetch_count), 128'd0);
      // basic refill and minimum latency
      request(13'h0A5, 2'd0, 4, 32'h1000);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!u_if.line_valid && n < 40);
      check("latency", 128'(n), 128'd9);
      check("lv_line_data", u_if.line_data, {32'h1003, 32'h1002, 32'h1001, 32'h1000});
      wait_lv(1);
      check("fc_after_first", 128'(u_if.fetch_count), 128'd1);
      // timeout with a silent memory
      resp_limit = resp_cnt;
      lv0 = lv_seen;
      request(13'h055, 2'd0, 1, 32'h0);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!u_if.err && n < 40);
      check("err_latency", 128'(n), 128'd5);
      check("ready_at_err", 128'(u_if.req_ready), 128'd1);
      @(posedge clk);
      #1;
      check("err_one_cycle", 128'(u_if.err), 128'd0);
      check("no_lv_on_timeout", 128'(lv_seen), 128'(lv0));
      check("fc_on_timeout", 128'(u_if.fetch_count), 128'(exp_fc));
      check("line_kept", u_if.line_data, {32'h1003, 32'h1002, 32'h1001, 32'h1000});
      resp_limit = 1000000;
      // wrap order when critical-word-first is built in; absolute slots either way
      request(13'h0001, 2'd3, 4, 32'h2000);
      wait_lv(lv0 + 1);
      // reset while waiting on word 2, then a stray rvalid
      resp_limit = resp_cnt + 2;
      rd0 = rd_seen;
      lv0 = lv_seen;
      request(13'h0123, 2'd0, 3, 32'h4000);
      for (c = 0; c < 40 && rd_seen < rd0 + 3; c++) begin
         @(negedge clk);
         #2;
      end
      check("reached_word2", 128'(rd_seen), 128'(rd0 + 3));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 128'(u_if.req_ready), 128'd1);
      check("mid_rst_mem_addr", 128'(u_if.mem_addr), 128'd0);
      check("mid_rst_line_data", u_if.line_data, 128'd0);
      check("mid_rst_fc", 128'(u_if.fetch_count), 128'd0);
      exp_fc = '0;
      @(negedge clk);
      rst = 1'b0;
      inj_req++;
      repeat (3) @(negedge clk);
      #2;
      check("late_rvalid_ready", 128'(u_if.req_ready), 128'd1);
      check("late_rvalid_line", u_if.line_data, 128'd0);
      check("late_rvalid_mem_rd", 128'(u_if.mem_rd), 128'd0);
      check("late_rvalid_no_lv", 128'(lv_seen), 128'(lv0));
      resp_limit = 1000000;
      // back-to-back with req_valid held high
      lv0 = lv_seen;
      @(negedge clk);
      expect_fetch(13'h0F0, 2'd1, 4, 32'h3000);
      expect_fetch(13'h0F0, 2'd1, 4, 32'h3000);
      u_if.req_valid = 1'b1;
      u_if.req_block_addr = 13'h0F0;
      u_if.req_offset = 2'd1;
      acc = 0;
      t1 = 0;
      t2 = 0;
      for (c = 0; c < 60 && acc < 2; c++) begin
         if (u_if.req_ready) begin
            acc++;
            if (acc == 1) t1 = c;
            else t2 = c;
         end
         if (acc < 2) @(negedge clk);
      end
      @(posedge clk);
      #1 u_if.req_valid = 1'b0;
      check("b2b_gap", 128'(t2 - t1), 128'd10);
      wait_lv(lv0 + 2);
      check("b2b_fc", 128'(u_if.fetch_count), 128'd2);
      // saturation from a forced near-full count
      @(negedge clk);
      force u_if.fetch_count = 16'hFFFE;
      @(negedge clk);
      release u_if.fetch_count;
      exp_fc = 16'hFFFE;
      #1;
      check("fc_preload", 128'(u_if.fetch_count), 128'hFFFE);
      lv0 = lv_seen;
      request(13'h1ABC, 2'd2, 4, 32'h5000);
      wait_lv(lv0 + 1);
      request(13'h0777, 2'd1, 4, 32'h6000);
      wait_lv(lv0 + 2);
      check("fc_saturated", 128'(u_if.fetch_count), 128'hFFFF);
      repeat (2) @(negedge clk);
      check("addr_q_drained", 128'(exp_addr.size()), 128'd0);
      check("line_q_drained", 128'(exp_line.size()), 128'd0);
      check("err_pulses", 128'(err_seen), 128'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
